edge_event_scheduler: RTL
=========================

EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 Parameter: W, 32, number of edge channels; SHALL be supported at W=32, legal range 2..32.
REQ-002 Derived width: IW = clog2(W), width of out_index (5 at W=32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 edge_in  input  W  one-cycle rising-edge event pulses, one bit per channel, driven from the rising-edge detector output.
REQ-006 enable_mask  input  W  per-channel capture enable; 1 = capture.
REQ-007 flush  input  1  synchronous discard of all pending events.
REQ-008 clear_ovf  input  1  synchronous clear of all overflow flags.
REQ-009 out_ready  input  1  consumer accepts the offered event.
REQ-010 out_valid  output  1  an event is offered.
REQ-011 out_index  output  IW  channel number of the offered event.
REQ-012 pending  output  W  registered per-channel pending flags.
REQ-013 overflow  output  W  sticky per-channel overflow flags.

Function
REQ-014 Capture: pending[i] SHALL set on the cycle after edge_in[i]=1 while enable_mask[i]=1; masked edges are dropped; the mask SHALL NOT clear existing pending bits.
REQ-015 Overflow: edge_in[i]=1 and enable_mask[i]=1 while pending[i]=1, and i not being retired this cycle, SHALL set overflow[i]; the event merges and no second grant is produced.
REQ-016 Retire: out_valid=1 and out_ready=1 in the same cycle SHALL clear pending[out_index] at the next edge, unless a new enabled edge arrives on that channel in that cycle; then pending stays 1 and overflow does not set.
REQ-017 FSM states: IDLE and OFFER only.
REQ-018 IDLE: if pending is nonzero, load out_index with the round-robin winner, drive out_valid=1 next cycle, go to OFFER; otherwise stay in IDLE with out_valid=0.
REQ-019 Round-robin: search starts at (last_grant+1) mod W, ascends, and wraps from W-1 to 0; the first set pending bit wins.
REQ-020 OFFER: out_valid and out_index SHALL stay stable while out_ready=0, regardless of mask changes or new edges.
REQ-021 OFFER with out_ready=1: last_grant becomes out_index, out_valid=0 next cycle, go to IDLE; the maximum rate is one grant per 2 cycles.
REQ-022 Latency: edge_in at cycle N, with the scheduler idle and the channel winning, gives pending at N+1 and out_valid at N+2.
REQ-023 flush=1: pending becomes 0, out_valid becomes 0, FSM goes to IDLE next cycle; edges in the flush cycle are discarded; overflow and last_grant are unchanged.
REQ-024 flush takes priority over capture and retire; it is ignored by the handshake, so an accept in a flush cycle does not update last_grant.
REQ-025 clear_ovf=1 clears overflow next cycle; an overflow condition in the same cycle wins, and that bit reads 1.
REQ-026 out_index SHALL hold its last value when out_valid=0.

Reset
REQ-027 reset SHALL take priority over all inputs.
REQ-028 Values one cycle after reset is sampled high: pending=0, overflow=0, out_valid=0, out_index=0, last_grant=W-1 (first search starts at 0), FSM in IDLE.
REQ-029 Edges sampled during reset SHALL be discarded; reset mid-OFFER drops the offer without retiring the event.

Verification
REQ-030 Single event: mask=all-1s, edge_in=0x0000_0008 at cycle 0, out_ready=1 -> pending[3]=1 at cycle 1, out_valid=1 with out_index=3 at cycle 2, pending=0 and out_valid=0 at cycle 3.
REQ-031 Round-robin wrap: pending={0,5,31}, last_grant=5, out_ready=1 -> grant order 31, 0, 5, each out_valid pulse separated by one idle cycle.
REQ-032 Backpressure and overflow: offer index 7, out_ready=0 for 4 cycles, edge_in[7] pulses -> out_index holds at 7, overflow[7]=1, a single grant after out_ready=1, then pending=0.
REQ-033 Retire collision: accept of index 2 in the same cycle as edge_in[2]=1 -> pending[2] stays 1, overflow[2]=0, index 2 re-offered after other winners.
REQ-034 Mask and flush: mask=0xFFFF_FFFE, edge_in=0x3 -> only pending[1] is set; then flush during OFFER -> out_valid=0 and pending=0 next cycle, last_grant unchanged.
REQ-035 Reset mid-OFFER: reset=1 for 1 cycle while out_valid=1 -> all outputs at their reset values next cycle, and the next grant searches from channel 0.

Source files
------------

// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler
//
// Collects one-cycle rising-edge event pulses from W channels into per-channel
// pending flags and hands them out one at a time through a valid/ready port.
// Channels are served round-robin, starting just after the most recently
// granted channel. An edge that lands on an already pending channel merges
// with it and raises a sticky overflow flag for that channel.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high; overrides every other input
//   edge_in      [W]  edge event pulses, one bit per channel
//   enable_mask  [W]  per-channel capture enable (1 = capture)
//   flush        drop every pending event and any offer in progress
//   clear_ovf    clear all overflow flags
//   out_ready    consumer accepts the offered event
//   out_valid    an event is being offered
//   out_index    [IW] channel number of the offered event, held while idle
//   pending      [W]  per-channel pending flags
//   overflow     [W]  sticky per-channel overflow flags
module edge_event_scheduler #(
    parameter int W = 32,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  edge_in,
    input  logic [W-1:0]  enable_mask,
    input  logic          flush,
    input  logic          clear_ovf,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_index,
    output logic [W-1:0]  pending,
    output logic [W-1:0]  overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // After reset the first search has to begin at channel 0.
    localparam logic [IW-1:0] LAST_INIT = IW'(W - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] last_nxt;
    logic [IW-1:0] idx_nxt;

    logic          accept;
    logic [W-1:0]  cap;
    logic [W-1:0]  retire_vec;
    logic [W-1:0]  ovf_set;
    logic [W-1:0]  pending_nxt;
    logic [W-1:0]  overflow_nxt;

    // First set request found scanning upward from last+1, wrapping at W-1.
    function automatic logic [IW-1:0] rr_pick(input logic [W-1:0] req,
                                              input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        logic [IW-1:0] cand;
        logic          hit;
        int            c;
        pick = last;
        hit  = 1'b0;
        for (int k = 1; k <= W; k++) begin
            c    = (int'(last) + k) % W;
            cand = c[IW-1:0];
            if (!hit && req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
        return pick;
    endfunction

    assign out_valid = (state == OFFER);

    // Capture / retire / overflow bookkeeping
    always_comb begin
        // A flush cancels the handshake, so nothing retires in that cycle.
        accept     = out_valid && out_ready && !flush;
        cap        = flush ? '0 : (edge_in & enable_mask);
        retire_vec = accept ? (W'(1) << out_index) : '0;
        // An edge on the channel being retired re-arms it instead of
        // counting as an overflow.
        ovf_set      = cap & pending & ~retire_vec;
        pending_nxt  = flush ? '0 : ((pending & ~retire_vec) | cap);
        overflow_nxt = (clear_ovf ? '0 : overflow) | ovf_set;
    end

    // Scheduler FSM: next state and grant bookkeeping
    always_comb begin
        state_nxt = state;
        idx_nxt   = out_index;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (!flush && (|pending)) begin
                    state_nxt = OFFER;
                    idx_nxt   = rr_pick(pending, last_grant);
                end
            end
            OFFER: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                    last_nxt  = out_index;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_index  <= '0;
            last_grant <= LAST_INIT;
            pending    <= '0;
            overflow   <= '0;
        end else begin
            state      <= state_nxt;
            out_index  <= idx_nxt;
            last_grant <= last_nxt;
            pending    <= pending_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule
